// File: rtl/eth_mdio_pkg.sv
// Shared MDIO frame constants, command record, state enum and frame helpers.
// Pure declarations: no latency, no flow control.
// Used by mdio_master (TA check gated by MDIO_TA_CHECK_EN in the top).
package eth_mdio_pkg;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  localparam int PRE_LEN   = 32;
  localparam int FRAME_LEN = 64;
  localparam int HDR_LEN   = 14;
  localparam int TA_LEN    = 2;
  localparam int DATA_LEN  = 16;
  localparam int BIT_CNT_W = $clog2(PRE_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_FIN
  } mdio_state_e;

  typedef struct packed {
    logic        write;
    logic [4:0]  phy_addr;
    logic [4:0]  reg_addr;
    logic [15:0] wdata;
  } mdio_cmd_t;

  // Read frames carry ones in TA/DATA; the pad is released there anyway.
  function automatic logic [FRAME_LEN-1:0] build_frame(input mdio_cmd_t cmd);
    build_frame = {{PRE_LEN{1'b1}}, MDIO_ST,
                   cmd.write ? MDIO_OP_WR : MDIO_OP_RD,
                   cmd.phy_addr, cmd.reg_addr,
                   cmd.write ? MDIO_TA_WR : 2'b11,
                   cmd.write ? cmd.wdata : 16'hFFFF};
  endfunction

  function automatic logic [BIT_CNT_W-1:0] last_bit(input mdio_state_e s);
    case (s)
      S_PRE:   last_bit = BIT_CNT_W'(PRE_LEN - 1);
      S_HDR:   last_bit = BIT_CNT_W'(HDR_LEN - 1);
      S_TA:    last_bit = BIT_CNT_W'(TA_LEN - 1);
      S_DATA:  last_bit = BIT_CNT_W'(DATA_LEN - 1);
      default: last_bit = '0;
    endcase
  endfunction

  function automatic mdio_state_e next_state(input mdio_state_e s);
    case (s)
      S_PRE:   next_state = S_HDR;
      S_HDR:   next_state = S_TA;
      S_TA:    next_state = S_DATA;
      S_DATA:  next_state = S_FIN;
      default: next_state = S_IDLE;
    endcase
  endfunction

  function automatic logic drive_en(input mdio_state_e s, input logic write);
    case (s)
      S_PRE, S_HDR:  drive_en = 1'b1;
      S_TA, S_DATA:  drive_en = write;
      default:       drive_en = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: CLK_DIV cycles per half-period, low half first, ticks on last cycle of each half.
// Latency: mdc registered; ticks combinational from the counter.
// Backpressure: none; held at zero while en is low, quiet suppresses the high half.
module mdio_clk_gen #(
  parameter int CLK_DIV = 45
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic en,
  input  logic quiet,
  output logic mdc,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HLAST = HW'(CLK_DIV - 1);

  logic [HW-1:0] hcnt;
  logic          phase;
  logic          half_done;

  assign half_done = (hcnt == HLAST);

  always_ff @(posedge sys_clk) begin
    if (rst || !en) begin
      hcnt  <= '0;
      phase <= 1'b0;
      mdc   <= 1'b0;
    end else if (half_done) begin
      hcnt  <= '0;
      phase <= ~phase;
      mdc   <= ~phase & ~quiet;
    end else begin
      hcnt  <= hcnt + 1'b1;
    end
  end

  assign rise_tick = en & half_done & ~phase;
  assign fall_tick = en & half_done & phase;

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: one read/write frame per accepted command; MDIO_TA_CHECK_EN adds a read TA check.
// Latency: accept at T gives rsp_valid at T+1+65*2*CLK_DIV.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are dropped, not queued.
module mdio_master
  import eth_mdio_pkg::*;
#(
  parameter int CLK_DIV = 45
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  mdio_state_e          state_q, state_nxt;
  logic [BIT_CNT_W-1:0] bit_q;
  logic [FRAME_LEN-1:0] shreg;
  logic [DATA_LEN-1:0]  rd_sh, rd_result;
  logic                 wr_q, accept, done, oe_nxt;
  logic                 fall_tick, rise_tick;
  mdio_cmd_t            cmd_in;

  assign cmd_in = {cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata};
  assign accept = cmd_valid & cmd_ready;

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .en        (state_q != S_IDLE),
    .quiet     (state_q == S_FIN),
    .mdc       (mdc),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  // A bit ends on the fall tick; the state advances after its last bit.
  always_comb begin
    state_nxt = state_q;
    if (state_q == S_IDLE) begin
      if (accept) state_nxt = S_PRE;
    end else if (fall_tick && bit_q == last_bit(state_q)) begin
      state_nxt = next_state(state_q);
    end
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE) && !rst;
    busy      = (state_q != S_IDLE);
    done      = fall_tick && (state_q == S_FIN);
  end

  // state_nxt only moves on accept or a fall tick, so oe only changes at bit start.
  assign oe_nxt = drive_en(state_nxt, wr_q);
  assign mdio_o = shreg[FRAME_LEN-1];

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      bit_q     <= '0;
      shreg     <= '1;
      wr_q      <= 1'b0;
      mdio_oe   <= 1'b0;
      rd_sh     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= done;
      mdio_oe   <= oe_nxt;
      if (accept) begin
        bit_q <= '0;
        shreg <= build_frame(cmd_in);
        wr_q  <= cmd_write;
      end else if (fall_tick) begin
        bit_q <= (bit_q == last_bit(state_q)) ? '0 : bit_q + 1'b1;
        shreg <= {shreg[FRAME_LEN-2:0], 1'b1};
      end
      if (rise_tick && state_q == S_DATA) rd_sh <= {rd_sh[DATA_LEN-2:0], mdio_i};
      if (done && !wr_q) rsp_rdata <= rd_result;
    end
  end

`ifdef MDIO_TA_CHECK_EN
  logic ta_err;

  // A PHY that answers pulls the second TA bit low; a high bit means nobody is there.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      ta_err  <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (accept)
        ta_err <= 1'b0;
      else if (rise_tick && state_q == S_TA && bit_q == BIT_CNT_W'(1) && !wr_q)
        ta_err <= mdio_i;
      if (done) rsp_err <= ta_err & ~wr_q;
    end
  end

  assign rd_result = ta_err ? 16'hFFFF : rd_sh;
`else
  assign rsp_err   = 1'b0;
  assign rd_result = rd_sh;
`endif

endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master (CLK_DIV=2 instance plus a default CLK_DIV=45 instance).
// Expected waveforms come from bit-index arithmetic on the frame layout; MDIO_TA_CHECK_EN honoured.
module tb_mdio_master;

  localparam int D         = 2;
  localparam int BT        = 2 * D;
  localparam int FRAME_CYC = 65 * BT;
  localparam int D45       = 45;

`ifdef MDIO_TA_CHECK_EN
  localparam bit TA_CHK = 1'b1;
`else
  localparam bit TA_CHK = 1'b0;
`endif

  logic        sys_clk, rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_phy_addr, cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_err, busy, mdc, mdio_o, mdio_oe, mdio_i;
  logic [15:0] rsp_rdata;

  logic        b_cmd_valid, b_cmd_ready, b_cmd_write;
  logic [4:0]  b_cmd_phy_addr, b_cmd_reg_addr;
  logic [15:0] b_cmd_wdata;
  logic        b_rsp_valid, b_rsp_err, b_busy, b_mdc, b_mdio_o, b_mdio_oe, b_mdio_i;
  logic [15:0] b_rsp_rdata;

  int checks;
  int errors;

  mdio_master #(.CLK_DIV(D)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  mdio_master dut45 (
    .sys_clk(sys_clk), .rst(rst),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
    .cmd_phy_addr(b_cmd_phy_addr), .cmd_reg_addr(b_cmd_reg_addr), .cmd_wdata(b_cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy),
    .mdc(b_mdc), .mdio_o(b_mdio_o), .mdio_oe(b_mdio_oe), .mdio_i(b_mdio_i)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  typedef struct {
    bit        wr;
    bit [4:0]  phy;
    bit [4:0]  rg;
    bit [15:0] wdata;
    bit [1:0]  ta;
    bit [15:0] pdata;
    bit [15:0] exp_rdata;
    bit        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_frame(input vec_t v);
    ref_frame = {32'hFFFF_FFFF, 2'b01, v.wr ? 2'b01 : 2'b10, v.phy, v.rg,
                 v.wr ? 2'b10 : 2'b00, v.wr ? v.wdata : 16'h0000};
  endfunction

  // What a PHY (or the pull-up) presents on the pad during frame bit b.
  function automatic logic phy_bit(input int b, input bit [1:0] ta, input bit [15:0] pd);
    if (b == 46)                phy_bit = ta[1];
    else if (b == 47)           phy_bit = ta[0];
    else if (b >= 48 && b < 64) phy_bit = pd[63 - b];
    else                        phy_bit = 1'b1;
  endfunction

  task automatic drive_cmd(input vec_t v);
    cmd_write    = v.wr;
    cmd_phy_addr = v.phy;
    cmd_reg_addr = v.rg;
    cmd_wdata    = v.wdata;
  endtask

  // Entered on the intended accept cycle; returns on the completion cycle.
  task automatic run_frame(input vec_t v, input bit hold, input vec_t nxt,
                           output logic [15:0] rd, output logic er,
                           output logic [63:0] stream, output int werr, output int lat);
    int b, ph;
    logic prev_o;
    logic e_mdc, e_oe;
    drive_cmd(v);
    cmd_valid = 1'b1;
    check("accept_ready", {63'd0, cmd_ready}, 64'd1);
    werr = 0; lat = -1; stream = '0; prev_o = mdio_o;
    for (int c = 0; c <= FRAME_CYC; c++) begin
      @(posedge sys_clk); #1;
      if (c == 0 && !hold) cmd_valid = 1'b0;
      if (c == 7 && hold) drive_cmd(nxt);
      b  = c / BT;
      ph = c % BT;
      mdio_i = phy_bit(b, v.ta, v.pdata);
      if (c < FRAME_CYC) begin
        e_mdc = (b < 64) && (ph >= D);
        e_oe  = (b < 46) || ((b < 64) && v.wr);
        if (mdc !== e_mdc || mdio_oe !== e_oe || busy !== 1'b1 || cmd_ready !== 1'b0 ||
            rsp_valid !== 1'b0 || (mdio_o !== prev_o && ph != 0)) begin
          if (werr == 0)
            $display("  first waveform difference at bit %0d phase %0d: mdc=%b oe=%b busy=%b rdy=%b vld=%b",
                     b, ph, mdc, mdio_oe, busy, cmd_ready, rsp_valid);
          werr++;
        end
        if (b < 64 && ph == D) stream[63 - b] = mdio_o;
      end else if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
        werr++;
      end
      if (rsp_valid === 1'b1 && lat < 0) lat = c + 1;
      prev_o = mdio_o;
    end
    rd = rsp_rdata;
    er = rsp_err;
    mdio_i = 1'b1;
  endtask

  task automatic do_frame(input string tag, input vec_t v, input bit hold, input vec_t nxt,
                          input logic [15:0] exp_rd, input logic exp_er);
    logic [15:0] rd;
    logic        er;
    logic [63:0] stream, mask;
    int          werr, lat;
    run_frame(v, hold, nxt, rd, er, stream, werr, lat);
    mask = v.wr ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFC_0000;
    check({tag, "_wave"},    64'(werr), 64'd0);
    check({tag, "_latency"}, 64'(lat), 64'(1 + FRAME_CYC));
    check({tag, "_stream"},  stream & mask, ref_frame(v) & mask);
    check({tag, "_rdata"},   {48'd0, rd}, {48'd0, exp_rd});
    check({tag, "_err"},     {63'd0, er}, {63'd0, exp_er});
  endtask

  vec_t        tbl [6];
  vec_t        va, vb, vr;
  logic [15:0] m_rdata;
  logic        m_err;

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; cmd_valid = 1'b0; mdio_i = 1'b1;
    cmd_write = 1'b0; cmd_phy_addr = '0; cmd_reg_addr = '0; cmd_wdata = '0;
    b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_cmd_phy_addr = '0; b_cmd_reg_addr = '0;
    b_cmd_wdata = '0; b_mdio_i = 1'b1;

    //            wr   phy    reg    wdata     ta     pdata     exp_rdata  exp_err
    tbl[0] = '{1'b1, 5'd1,  5'd0,  16'h1140, 2'b11, 16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 5'd1,  5'd2,  16'h0000, 2'b10, 16'h0022, 16'h0022, 1'b0};
    tbl[2] = '{1'b0, 5'd1,  5'd3,  16'h0000, 2'b11, 16'hFFFF, 16'hFFFF, TA_CHK};
    tbl[3] = '{1'b0, 5'd31, 5'd31, 16'h0000, 2'b10, 16'hA5C3, 16'hA5C3, 1'b0};
    tbl[4] = '{1'b1, 5'd5,  5'd9,  16'hBEEF, 2'b11, 16'h0000, 16'hA5C3, 1'b0};
    tbl[5] = '{1'b0, 5'd7,  5'd4,  16'h0000, 2'b11, 16'h1234,
               TA_CHK ? 16'hFFFF : 16'h1234, TA_CHK};

    repeat (4) @(posedge sys_clk);
    #1;
    check("rst_mdc",    {63'd0, mdc},       64'd0);
    check("rst_mdio_o", {63'd0, mdio_o},    64'd1);
    check("rst_oe",     {63'd0, mdio_oe},   64'd0);
    check("rst_vld",    {63'd0, rsp_valid}, 64'd0);
    check("rst_err",    {63'd0, rsp_err},   64'd0);
    check("rst_rdata",  {48'd0, rsp_rdata}, 64'd0);
    check("rst_busy",   {63'd0, busy},      64'd0);
    check("rst_ready",  {63'd0, cmd_ready}, 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {63'd0, cmd_ready}, 64'd1);
    @(posedge sys_clk); #1;

    for (int i = 0; i < 6; i++) begin
      do_frame($sformatf("tbl%0d", i), tbl[i], 1'b0, tbl[i], tbl[i].exp_rdata, tbl[i].exp_err);
      m_rdata = tbl[i].exp_rdata;
    end
    @(posedge sys_clk); #1;
    check("vld_single_pulse", {63'd0, rsp_valid}, 64'd0);

    va = '{1'b1, 5'd2, 5'd3, 16'hCAFE, 2'b11, 16'h0000, 16'h0000, 1'b0};
    vb = '{1'b0, 5'd4, 5'd1, 16'h0000, 2'b10, 16'h5A5A, 16'h0000, 1'b0};
    do_frame("b2b_first", va, 1'b1, vb, m_rdata, 1'b0);
    do_frame("b2b_second", vb, 1'b0, vb, 16'h5A5A, 1'b0);
    m_rdata = 16'h5A5A;

    for (int k = 0; k < 6; k++) begin
      vr.wr    = 1'($urandom_range(0, 1));
      vr.phy   = 5'($urandom);
      vr.rg    = 5'($urandom);
      vr.wdata = 16'($urandom);
      vr.ta    = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b10;
      vr.pdata = 16'($urandom);
      m_err    = !vr.wr && TA_CHK && vr.ta[0];
      m_rdata  = vr.wr ? m_rdata : (m_err ? 16'hFFFF : vr.pdata);
      vr.exp_rdata = m_rdata;
      vr.exp_err   = m_err;
      do_frame($sformatf("rnd%0d", k), vr, 1'b0, vr, m_rdata, m_err);
    end

    // Abort a write during DATA bit 5.
    vr = '{1'b1, 5'd6, 5'd7, 16'h1234, 2'b11, 16'h0000, 16'h0000, 1'b0};
    drive_cmd(vr);
    cmd_valid = 1'b1;
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    repeat (53 * BT + 1) @(posedge sys_clk);
    #1;
    check("abort_busy_before", {62'd0, busy, mdio_oe}, 64'd3);
    rst = 1'b1;
    @(posedge sys_clk); #1;
    check("abort_mdc",  {63'd0, mdc},     64'd0);
    check("abort_oe",   {63'd0, mdio_oe}, 64'd0);
    check("abort_busy", {63'd0, busy},    64'd0);
    rst = 1'b0;
    #1;
    check("abort_ready", {63'd0, cmd_ready}, 64'd1);
    begin
      int vcnt;
      vcnt = 0;
      repeat (2 * FRAME_CYC) begin
        @(posedge sys_clk); #1;
        if (rsp_valid === 1'b1) vcnt++;
      end
      check("abort_no_rsp", 64'(vcnt), 64'd0);
    end

    // Default divider: MDC shape and mdio_o change points.
    begin
      int werr, lat, rise1, rise2, hi_cnt, b, ph;
      logic prev_o, prev_mdc, e_mdc;
      werr = 0; lat = -1; rise1 = -1; rise2 = -1; hi_cnt = 0;
      b_cmd_write = 1'b1; b_cmd_phy_addr = 5'd3; b_cmd_reg_addr = 5'd4; b_cmd_wdata = 16'h8001;
      b_cmd_valid = 1'b1;
      check("d45_accept_ready", {63'd0, b_cmd_ready}, 64'd1);
      prev_o = b_mdio_o; prev_mdc = b_mdc;
      for (int c = 0; c <= 130 * D45; c++) begin
        @(posedge sys_clk); #1;
        if (c == 0) b_cmd_valid = 1'b0;
        b  = c / (2 * D45);
        ph = c % (2 * D45);
        if (c < 130 * D45) begin
          e_mdc = (b < 64) && (ph >= D45);
          if (b_mdc !== e_mdc || b_mdio_oe !== (b < 64) || b_busy !== 1'b1 ||
              (b_mdio_o !== prev_o && ph != 0))
            werr++;
          if (c < 2 * D45 && b_mdc === 1'b1) hi_cnt++;
          if (b_mdc === 1'b1 && prev_mdc === 1'b0) begin
            if (rise1 < 0) rise1 = c;
            else if (rise2 < 0) rise2 = c;
          end
        end
        if (b_rsp_valid === 1'b1 && lat < 0) lat = c + 1;
        prev_o = b_mdio_o; prev_mdc = b_mdc;
      end
      check("d45_wave",    64'(werr), 64'd0);
      check("d45_period",  64'(rise2 - rise1), 64'd90);
      check("d45_high",    64'(hi_cnt), 64'd45);
      check("d45_latency", 64'(lat), 64'(1 + 130 * D45));
      check("d45_rsp",     {47'd0, b_rsp_err, b_rsp_rdata}, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
